pll_phase_mgr: RTL and testbench
================================

# pll_phase_mgr

Controller that sits beside the ECP5 EHXPLLL in the clock tree, clocked from the 25 MHz board oscillator. It qualifies the raw PLL lock, sequences PLL reset with timeout and retry, releases N downstream domain resets in staggered order, and drives the PLL dynamic-phase ports (PHASESEL/PHASEDIR/PHASESTEP) as a request/done step engine. The top level wires its PLL-side ports directly to the EHXPLLL instance.

## Interface
- N_DOM, 2: number of downstream domain reset outputs (1..8)
- RST_CYCLES, 16: pll_rst high time per reset attempt
- LOCK_CYCLES, 1024: consecutive synchronised lock-high cycles before `locked`
- TIMEOUT_CYCLES, 65536: wait for lock after pll_rst release before retrying
- STAGGER, 8: cycles between successive domain reset releases
- STEP_LOW, 4 / STEP_HIGH, 4: phasestep low and high time per step
---
- clk_25mhz  in  1  controller clock
- rst  in  1  asynchronous, active-high reset
- pll_lock  in  1  raw EHXPLLL LOCK (asynchronous)
- pll_rst  out  1  to EHXPLLL RST
- phasesel  out  2  to PHASESEL1:0
- phasedir  out  1  to PHASEDIR
- phasestep  out  1  to PHASESTEP, idle high
- locked  out  1  qualified lock
- rst_dom  out  N_DOM  domain resets, active high
- retries  out  4  saturating count of lock timeouts
- step_req  in  1  start a phase-step sequence (sampled while idle)
- step_sel  in  2  output to shift
- step_dir  in  1  step direction
- step_cnt  in  8  number of steps
- step_busy  out  1  sequence in progress
- step_done  out  1  one-cycle pulse, sequence finished
- step_err  out  1  one-cycle pulse with step_done when aborted

## Operation
- Reset values: pll_rst=1, locked=0, rst_dom=all 1, retries=0, phasestep=1, phasesel=0, phasedir=0, step_busy=0, step_done=0, step_err=0.
- pll_lock passes a 2-FF synchroniser; all logic uses the synchronised value.
- Main FSM: S_PLLRST → S_WAIT → S_RUN.
  - S_PLLRST: pll_rst=1 for RST_CYCLES, then S_WAIT.
  - S_WAIT: counter counts consecutive lock-high cycles; any low sample clears it. At LOCK_CYCLES → S_RUN, locked=1. Elapsed counter reaching TIMEOUT_CYCLES → retries+1 (saturates at 15), → S_PLLRST.
  - S_RUN: any low sample → locked=0, all rst_dom=1 same edge, → S_PLLRST.
- rst_dom[i] deasserts STAGGER·(i+1) cycles after locked rises; all reassert together on lock loss or rst.
- Phase engine: P_IDLE → P_SETUP → P_LOW → P_HIGH → (P_LOW | P_DONE) → P_IDLE.
  - step_req accepted only in P_IDLE with locked=1; otherwise ignored (no done).
  - Accept: latch sel/dir/cnt onto phasesel/phasedir, step_busy=1; P_SETUP lasts 2 cycles.
  - Each step: phasestep low STEP_LOW cycles, then high STEP_HIGH cycles; repeat cnt times.
  - cnt=0: no pulses; P_SETUP then P_DONE.
  - P_DONE: step_done=1 one cycle, step_busy=0 next cycle; phasesel/phasedir hold last value.
  - locked falling in any non-idle state: phasestep=1 immediately, step_done=step_err=1 one cycle, → P_IDLE.
  - step_req while busy ignored.

## Timing
- locked rises exactly LOCK_CYCLES+2 clocks after pll_lock rises (stable), given S_WAIT.
- locked falls 3 clocks after pll_lock falls (2 sync + 1 register).
- Step sequence from accepting edge to step_done: 2 + cnt·(STEP_LOW+STEP_HIGH) + 1 cycles.
- phasesel/phasedir stable ≥2 cycles before first phasestep falling edge and through final rising edge.
- rst mid-sequence: all outputs to reset values asynchronously; sequence discarded.

## Configuration
- PLL_PHASE_STEP_EN defined: phase engine built as above.
- Undefined: engine removed; phasestep=1, phasesel=0, phasedir=0, step_busy/step_done/step_err=0 constantly; step inputs ignored. Lock/reset logic unchanged.

## Test plan
- Defaults, pll_lock high from cycle 20 → pll_rst low at 16, locked high at cycle 1046, rst_dom[0] low 8 later, rst_dom[1] low 16 later.
- pll_lock glitch low 1 cycle at 500 lock-high cycles → counter restarts; locked 1026 cycles after glitch ends.
- pll_lock never high, TIMEOUT_CYCLES=100 → pll_rst re-pulses every 116 cycles; retries stops at 15.
- Locked, step_req sel=2 dir=1 cnt=3 → phasesel=2, phasedir=1, three 4-low/4-high pulses, step_done 27 cycles after accept, step_err=0.
- Mid-sequence pll_lock low → phasestep high within 3 cycles, step_done+step_err pulse, rst_dom all high, pll_rst high.
- cnt=0 request → no phasestep activity, step_done 3 cycles after accept; request with locked=0 → no response.

Source files
------------

// File: rtl/pll_phase_mgr.sv
// pll_phase_mgr
// Sits beside the ECP5 EHXPLLL on the 25 MHz board oscillator.
//   - qualifies the raw PLL LOCK through a 2-FF synchroniser and a
//     consecutive-high counter
//   - sequences PLL reset with a lock timeout and a saturating retry count
//   - releases N_DOM downstream domain resets in staggered order
//   - optionally drives the PLL dynamic-phase ports as a request/done engine
// Optional feature macro: PLL_PHASE_STEP_EN (defined = phase engine built,
// undefined = phase outputs tied to their idle values, step inputs ignored).
// Ports:
//   clk_25mhz, rst (async, active high)    controller clock and reset
//   pll_lock                               raw EHXPLLL LOCK (asynchronous)
//   pll_rst, phasesel, phasedir, phasestep to the EHXPLLL
//   locked, rst_dom, retries               qualified lock, domain resets, timeouts
//   step_req/sel/dir/cnt                   phase-step request
//   step_busy, step_done, step_err         phase-step status
module pll_phase_mgr #(
    parameter int N_DOM          = 2,
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int STAGGER        = 8,
    parameter int STEP_LOW       = 4,
    parameter int STEP_HIGH      = 4
) (
    input  logic             clk_25mhz,
    input  logic             rst,
    input  logic             pll_lock,
    output logic             pll_rst,
    output logic [1:0]       phasesel,
    output logic             phasedir,
    output logic             phasestep,
    output logic             locked,
    output logic [N_DOM-1:0] rst_dom,
    output logic [3:0]       retries,
    input  logic             step_req,
    input  logic [1:0]       step_sel,
    input  logic             step_dir,
    input  logic [7:0]       step_cnt,
    output logic             step_busy,
    output logic             step_done,
    output logic             step_err
);

    // One shared timer serves all three main states: reset pulse length,
    // lock timeout, and the saturating stagger count while running.
    localparam int STG_MAX  = STAGGER * N_DOM;
    localparam int TIM_MAX0 = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int TIM_MAX  = (TIM_MAX0 > STG_MAX) ? TIM_MAX0 : STG_MAX;
    localparam int TIM_W    = $clog2(TIM_MAX + 1);
    localparam int LOCK_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [TIM_W-1:0]  TIM_RST_LAST = TIM_W'(RST_CYCLES - 1);
    localparam logic [TIM_W-1:0]  TIM_TMO_LAST = TIM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIM_W-1:0]  TIM_STG_MAX  = TIM_W'(STG_MAX);
    localparam logic [LOCK_W-1:0] LOCK_LAST    = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {S_PLLRST, S_WAIT, S_RUN} main_state_t;

    main_state_t       state_r, state_s;
    logic [TIM_W-1:0]  tim_r, tim_s;
    logic [LOCK_W-1:0] lock_cnt_r, lock_cnt_s;
    logic [3:0]        retries_r, retries_s;
    logic              lock_meta_r, lock_sync_r;
    logic              pll_rst_r, locked_r;
    logic [N_DOM-1:0]  rst_dom_r, rst_dom_s;
    logic              lock_drop_s;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Main FSM next-state: reset pulse, lock qualification/timeout, run
    always_comb begin
        state_s     = state_r;
        tim_s       = tim_r;
        lock_cnt_s  = lock_cnt_r;
        retries_s   = retries_r;
        lock_drop_s = 1'b0;
        case (state_r)
            S_PLLRST: begin
                lock_cnt_s = '0;
                if (tim_r == TIM_RST_LAST) begin
                    state_s = S_WAIT;
                    tim_s   = '0;
                end else begin
                    tim_s = tim_r + TIM_W'(1);
                end
            end
            S_WAIT: begin
                // Lock qualification wins over a timeout on the same cycle.
                if (lock_sync_r && (lock_cnt_r == LOCK_LAST)) begin
                    state_s    = S_RUN;
                    tim_s      = '0;
                    lock_cnt_s = '0;
                end else if (tim_r == TIM_TMO_LAST) begin
                    state_s    = S_PLLRST;
                    tim_s      = '0;
                    lock_cnt_s = '0;
                    if (retries_r != 4'hF) begin
                        retries_s = retries_r + 4'd1;
                    end else begin
                        retries_s = retries_r;
                    end
                end else begin
                    tim_s = tim_r + TIM_W'(1);
                    if (lock_sync_r) begin
                        lock_cnt_s = lock_cnt_r + LOCK_W'(1);
                    end else begin
                        lock_cnt_s = '0;
                    end
                end
            end
            S_RUN: begin
                if (!lock_sync_r) begin
                    state_s     = S_PLLRST;
                    tim_s       = '0;
                    lock_drop_s = 1'b1;
                end else if (tim_r != TIM_STG_MAX) begin
                    tim_s = tim_r + TIM_W'(1);
                end else begin
                    tim_s = tim_r;
                end
            end
            default: begin
                state_s    = S_PLLRST;
                tim_s      = '0;
                lock_cnt_s = '0;
            end
        endcase
    end

    // Domain reset i releases once the run timer reaches STAGGER*(i+1)
    always_comb begin
        rst_dom_s = '1;
        for (int i = 0; i < N_DOM; i++) begin
            if ((state_s == S_RUN) && (int'(tim_s) >= STAGGER * (i + 1))) begin
                rst_dom_s[i] = 1'b0;
            end else begin
                rst_dom_s[i] = 1'b1;
            end
        end
    end

    // Main FSM state, counters and registered lock-side outputs
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            state_r    <= S_PLLRST;
            tim_r      <= '0;
            lock_cnt_r <= '0;
            retries_r  <= 4'd0;
            pll_rst_r  <= 1'b1;
            locked_r   <= 1'b0;
            rst_dom_r  <= '1;
        end else begin
            state_r    <= state_s;
            tim_r      <= tim_s;
            lock_cnt_r <= lock_cnt_s;
            retries_r  <= retries_s;
            pll_rst_r  <= (state_s == S_PLLRST);
            locked_r   <= (state_s == S_RUN);
            rst_dom_r  <= rst_dom_s;
        end
    end

    assign pll_rst = pll_rst_r;
    assign locked  = locked_r;
    assign rst_dom = rst_dom_r;
    assign retries = retries_r;

`ifdef PLL_PHASE_STEP_EN
    localparam int PH_MAX0 = (STEP_LOW > STEP_HIGH) ? STEP_LOW : STEP_HIGH;
    localparam int PH_MAX  = (PH_MAX0 > 2) ? PH_MAX0 : 2;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] PH_SETUP_LAST = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LOW_LAST   = PH_W'(STEP_LOW - 1);
    localparam logic [PH_W-1:0] PH_HIGH_LAST  = PH_W'(STEP_HIGH - 1);

    typedef enum logic [2:0] {P_IDLE, P_SETUP, P_LOW, P_HIGH, P_DONE} phase_state_t;

    phase_state_t    p_state_r, p_state_s;
    logic [PH_W-1:0] p_tim_r, p_tim_s;
    logic [7:0]      steps_left_r, steps_left_s;
    logic [1:0]      phasesel_r, phasesel_s;
    logic            phasedir_r, phasedir_s;
    logic            phasestep_r, phasestep_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            err_r, err_s;

    // Phase engine next-state; lock loss aborts from any active state
    always_comb begin
        p_state_s    = p_state_r;
        p_tim_s      = p_tim_r;
        steps_left_s = steps_left_r;
        phasesel_s   = phasesel_r;
        phasedir_s   = phasedir_r;
        phasestep_s  = phasestep_r;
        done_s       = 1'b0;
        err_s        = 1'b0;
        if ((p_state_r != P_IDLE) && lock_drop_s) begin
            p_state_s   = P_IDLE;
            p_tim_s     = '0;
            phasestep_s = 1'b1;
            done_s      = 1'b1;
            err_s       = 1'b1;
        end else begin
            case (p_state_r)
                P_IDLE: begin
                    phasestep_s = 1'b1;
                    // busy_r still high here means the done cycle just ended.
                    if (step_req && locked_r && !lock_drop_s && !busy_r) begin
                        p_state_s    = P_SETUP;
                        p_tim_s      = '0;
                        phasesel_s   = step_sel;
                        phasedir_s   = step_dir;
                        steps_left_s = step_cnt;
                    end else begin
                        p_state_s = P_IDLE;
                    end
                end
                P_SETUP: begin
                    if (p_tim_r == PH_SETUP_LAST) begin
                        p_tim_s = '0;
                        if (steps_left_r == 8'd0) begin
                            p_state_s = P_DONE;
                        end else begin
                            p_state_s   = P_LOW;
                            phasestep_s = 1'b0;
                        end
                    end else begin
                        p_tim_s = p_tim_r + PH_W'(1);
                    end
                end
                P_LOW: begin
                    if (p_tim_r == PH_LOW_LAST) begin
                        p_tim_s     = '0;
                        p_state_s   = P_HIGH;
                        phasestep_s = 1'b1;
                    end else begin
                        p_tim_s = p_tim_r + PH_W'(1);
                    end
                end
                P_HIGH: begin
                    if (p_tim_r == PH_HIGH_LAST) begin
                        p_tim_s = '0;
                        if (steps_left_r == 8'd1) begin
                            p_state_s = P_DONE;
                        end else begin
                            steps_left_s = steps_left_r - 8'd1;
                            p_state_s    = P_LOW;
                            phasestep_s  = 1'b0;
                        end
                    end else begin
                        p_tim_s = p_tim_r + PH_W'(1);
                    end
                end
                P_DONE: begin
                    p_state_s = P_IDLE;
                    done_s    = 1'b1;
                end
                default: begin
                    p_state_s   = P_IDLE;
                    p_tim_s     = '0;
                    phasestep_s = 1'b1;
                end
            endcase
        end
        // busy covers the done cycle and drops on the following one
        busy_s = (p_state_s != P_IDLE) || done_s;
    end

    // Phase engine state and registered phase/status outputs
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            p_state_r    <= P_IDLE;
            p_tim_r      <= '0;
            steps_left_r <= 8'd0;
            phasesel_r   <= 2'd0;
            phasedir_r   <= 1'b0;
            phasestep_r  <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            p_state_r    <= p_state_s;
            p_tim_r      <= p_tim_s;
            steps_left_r <= steps_left_s;
            phasesel_r   <= phasesel_s;
            phasedir_r   <= phasedir_s;
            phasestep_r  <= phasestep_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            err_r        <= err_s;
        end
    end

    assign phasesel  = phasesel_r;
    assign phasedir  = phasedir_r;
    assign phasestep = phasestep_r;
    assign step_busy = busy_r;
    assign step_done = done_r;
    assign step_err  = err_r;
`else
    logic unused_step_s;
    assign unused_step_s = ^{step_req, step_sel, step_dir, step_cnt, lock_drop_s};

    assign phasesel  = 2'd0;
    assign phasedir  = 1'b0;
    assign phasestep = 1'b1;
    assign step_busy = 1'b0;
    assign step_done = 1'b0;
    assign step_err  = 1'b0;
`endif

endmodule

// File: tb/tb_pll_phase_mgr.sv
// Directed bench for pll_phase_mgr: lock qualification timing, staggered
// domain reset release, lock loss, glitch restart, timeout/retry saturation,
// async reset, and the phase-step engine (or its tied-off outputs when
// PLL_PHASE_STEP_EN is undefined).
module tb_pll_phase_mgr;
    localparam int N_DOM   = 2;
    localparam int TIMEOUT = 2000;

    logic       clk_25mhz = 1'b0;
    logic       rst       = 1'b1;
    logic       pll_lock  = 1'b0;
    logic       step_req  = 1'b0;
    logic [1:0] step_sel  = 2'd0;
    logic       step_dir  = 1'b0;
    logic [7:0] step_cnt  = 8'd0;
    logic       pll_rst, phasedir, phasestep, locked;
    logic [1:0] phasesel;
    logic [N_DOM-1:0] rst_dom;
    logic [3:0] retries;
    logic       step_busy, step_done, step_err;

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    pll_phase_mgr #(
        .N_DOM(N_DOM), .RST_CYCLES(16), .LOCK_CYCLES(1024), .TIMEOUT_CYCLES(TIMEOUT),
        .STAGGER(8), .STEP_LOW(4), .STEP_HIGH(4)
    ) dut (
        .clk_25mhz(clk_25mhz), .rst(rst), .pll_lock(pll_lock), .pll_rst(pll_rst),
        .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .locked(locked),
        .rst_dom(rst_dom), .retries(retries), .step_req(step_req), .step_sel(step_sel),
        .step_dir(step_dir), .step_cnt(step_cnt), .step_busy(step_busy),
        .step_done(step_done), .step_err(step_err)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    // Reset released between edges; the next rising edge is edge 1.
    task automatic do_reset(input logic lock_lvl);
        rst = 1'b1; pll_lock = lock_lvl; step_req = 1'b0;
        repeat (2) @(negedge clk_25mhz);
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_25mhz);
        n_cmp++;
        if ({pll_rst, locked, rst_dom, retries, phasestep, phasesel, phasedir, step_busy, step_done, step_err}
            !== 15'b1_0_11_0000_1_00_0_0_0_0) begin
            n_bad++;
            $display("FAIL reset_values: got %b expected 101100001000000",
                     {pll_rst, locked, rst_dom, retries, phasestep, phasesel, phasedir, step_busy, step_done, step_err});
        end
    endtask

    task automatic test_lock_timing();
        do_reset(1'b0);
        run_to(15);
        n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL pll_rst_e15: got %b expected 1", pll_rst); end
        run_to(16);
        n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL pll_rst_e16: got %b expected 0", pll_rst); end
        run_to(20);
        pll_lock = 1'b1;
        run_to(1045);
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL locked_e1045: got %b expected 0", locked); end
        run_to(1046);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL locked_e1046: got %b expected 1", locked); end
        n_cmp++; if (rst_dom !== 2'b11) begin n_bad++; $display("FAIL rst_dom_e1046: got %b expected 11", rst_dom); end
        run_to(1053);
        n_cmp++; if (rst_dom !== 2'b11) begin n_bad++; $display("FAIL rst_dom_e1053: got %b expected 11", rst_dom); end
        run_to(1054);
        n_cmp++; if (rst_dom !== 2'b10) begin n_bad++; $display("FAIL rst_dom_e1054: got %b expected 10", rst_dom); end
        run_to(1061);
        n_cmp++; if (rst_dom !== 2'b10) begin n_bad++; $display("FAIL rst_dom_e1061: got %b expected 10", rst_dom); end
        run_to(1062);
        n_cmp++; if (rst_dom !== 2'b00) begin n_bad++; $display("FAIL rst_dom_e1062: got %b expected 00", rst_dom); end
    endtask

`ifdef PLL_PHASE_STEP_EN
    task automatic test_phase_step();
        int lows = 0;
        int falls = 0;
        int dones = 0;
        logic prev;
        step_sel = 2'd2; step_dir = 1'b1; step_cnt = 8'd3; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        n_cmp++;
        if ({phasesel, phasedir, step_busy, phasestep} !== 5'b10111) begin
            n_bad++; $display("FAIL step_accept: got %b expected 10111", {phasesel, phasedir, step_busy, phasestep});
        end
        prev = phasestep;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (phasestep === 1'b0) lows++;
            if (prev === 1'b1 && phasestep === 1'b0) falls++;
            if (step_done !== 1'b0) dones++;
            if (k == 2) begin
                n_cmp++;
                if (phasestep !== 1'b0) begin n_bad++; $display("FAIL step_first_low: got %b expected 0", phasestep); end
            end
            prev = phasestep;
        end
        n_cmp++; if (lows !== 12) begin n_bad++; $display("FAIL step_low_cycles: got %0d expected 12", lows); end
        n_cmp++; if (falls !== 3) begin n_bad++; $display("FAIL step_pulses: got %0d expected 3", falls); end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL step_early_done: got %0d expected 0", dones); end
        tick();
        n_cmp++;
        if ({step_done, step_err, step_busy, phasestep} !== 4'b1011) begin
            n_bad++; $display("FAIL step_done_a27: got %b expected 1011", {step_done, step_err, step_busy, phasestep});
        end
        tick();
        n_cmp++;
        if ({step_done, step_busy, phasesel, phasedir} !== 5'b00101) begin
            n_bad++; $display("FAIL step_after_done: got %b expected 00101", {step_done, step_busy, phasesel, phasedir});
        end
    endtask

    task automatic test_step_cnt0();
        int lows = 0;
        step_sel = 2'd1; step_dir = 1'b0; step_cnt = 8'd0; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        if (phasestep === 1'b0) lows++;
        tick();
        if (phasestep === 1'b0) lows++;
        tick();
        if (phasestep === 1'b0) lows++;
        n_cmp++; if (step_done !== 1'b0) begin n_bad++; $display("FAIL cnt0_done_b2: got %b expected 0", step_done); end
        tick();
        if (phasestep === 1'b0) lows++;
        n_cmp++;
        if ({step_done, step_err, phasesel} !== 4'b1001) begin
            n_bad++; $display("FAIL cnt0_done_b3: got %b expected 1001", {step_done, step_err, phasesel});
        end
        n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL cnt0_no_pulse: got %0d low cycles expected 0", lows); end
        tick();
    endtask
`else
    task automatic test_step_disabled();
        int bad_samples = 0;
        step_sel = 2'd2; step_dir = 1'b1; step_cnt = 8'd3; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if ({phasestep, phasesel, phasedir, step_busy, step_done, step_err} !== 7'b1000000) bad_samples++;
            tick();
        end
        n_cmp++;
        if (bad_samples !== 0) begin n_bad++; $display("FAIL step_tied_off: got %0d bad samples expected 0", bad_samples); end
    endtask
`endif

    task automatic test_lock_loss();
        int e0;
`ifdef PLL_PHASE_STEP_EN
        step_sel = 2'd3; step_dir = 1'b0; step_cnt = 8'd3; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        tick();
`endif
        e0 = edge_n;
        pll_lock = 1'b0;
        run_to(e0 + 2);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loss_locked_e2: got %b expected 1", locked); end
`ifdef PLL_PHASE_STEP_EN
        n_cmp++; if (phasestep !== 1'b0) begin n_bad++; $display("FAIL loss_step_low_e2: got %b expected 0", phasestep); end
`endif
        run_to(e0 + 3);
        n_cmp++;
        if ({locked, rst_dom, pll_rst} !== 4'b0111) begin
            n_bad++; $display("FAIL loss_e3: got %b expected 0111", {locked, rst_dom, pll_rst});
        end
`ifdef PLL_PHASE_STEP_EN
        n_cmp++;
        if ({phasestep, step_done, step_err} !== 3'b111) begin
            n_bad++; $display("FAIL loss_abort: got %b expected 111", {phasestep, step_done, step_err});
        end
        tick();
        n_cmp++;
        if ({step_done, step_err, step_busy} !== 3'b000) begin
            n_bad++; $display("FAIL loss_after: got %b expected 000", {step_done, step_err, step_busy});
        end
`endif
    endtask

    task automatic test_req_unlocked();
        int hits = 0;
        step_cnt = 8'd0; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (step_busy !== 1'b0 || step_done !== 1'b0) hits++;
            tick();
        end
        n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL req_unlocked: got %0d busy/done samples expected 0", hits); end
    endtask

    task automatic test_glitch();
        do_reset(1'b1);
        run_to(516);
        pll_lock = 1'b0;
        run_to(517);
        pll_lock = 1'b1;
        run_to(1100);
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL glitch_e1100: got %b expected 0", locked); end
        run_to(1542);
        n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL glitch_e1542: got %b expected 0", locked); end
        run_to(1543);
        n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL glitch_e1543: got %b expected 1", locked); end
    endtask

    task automatic test_async_reset();
        run_to(1559);
        n_cmp++; if (rst_dom !== 2'b00) begin n_bad++; $display("FAIL pre_rst_dom: got %b expected 00", rst_dom); end
        @(negedge clk_25mhz);
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({locked, rst_dom, pll_rst} !== 4'b0111) begin
            n_bad++; $display("FAIL async_reset: got %b expected 0111", {locked, rst_dom, pll_rst});
        end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        run_to(2015);
        n_cmp++; if ({pll_rst, retries} !== 5'b00000) begin n_bad++; $display("FAIL tmo_e2015: got %b expected 00000", {pll_rst, retries}); end
        run_to(2016);
        n_cmp++; if ({pll_rst, retries} !== 5'b10001) begin n_bad++; $display("FAIL tmo_e2016: got %b expected 10001", {pll_rst, retries}); end
        run_to(2031);
        n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL tmo_e2031: got %b expected 1", pll_rst); end
        run_to(2032);
        n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL tmo_e2032: got %b expected 0", pll_rst); end
        run_to(4031);
        n_cmp++; if (retries !== 4'd1) begin n_bad++; $display("FAIL tmo_e4031: got %0d expected 1", retries); end
        run_to(4032);
        n_cmp++; if (retries !== 4'd2) begin n_bad++; $display("FAIL tmo_e4032: got %0d expected 2", retries); end
        run_to(30239);
        n_cmp++; if (retries !== 4'd14) begin n_bad++; $display("FAIL tmo_e30239: got %0d expected 14", retries); end
        run_to(30240);
        n_cmp++; if (retries !== 4'd15) begin n_bad++; $display("FAIL tmo_e30240: got %0d expected 15", retries); end
        run_to(32257);
        n_cmp++; if ({pll_rst, retries} !== 5'b11111) begin n_bad++; $display("FAIL tmo_saturate: got %b expected 11111", {pll_rst, retries}); end
    endtask

    initial begin
        test_reset();
        test_lock_timing();
`ifdef PLL_PHASE_STEP_EN
        test_phase_step();
        test_step_cnt0();
`else
        test_step_disabled();
`endif
        test_lock_loss();
        test_req_unlocked();
        test_glitch();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
